vga_sync_decoder: RTL and testbench

Recovers pixel coordinates and timing lock from a pair of VGA sync signals (HS/VS) in the 640x480 display path: the receiving end of the `vga640x480` timing generator. It measures line length and frame height, checks them against the expected 640x480@60 geometry and, once locked, reports the current x/y position and an active-video flag. It is used to loop back and check the generator on-board, and as the front end of a future VGA capture path.

---
 rtl/vga_sync_decoder_if.sv | 29 ++
 rtl/vga_sync_decoder.sv | 170 +++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_decoder_if.sv
`default_nettype none
//==============================================================================
// Module  : vga_sync_decoder_if
// Brief   : Sync inputs and decoded position/lock outputs of vga_sync_decoder.
// Revision: 1.0
//==============================================================================
interface vga_sync_decoder_if;
   logic       i_pix_stb;
   logic       i_hs;
   logic       i_vs;
   logic [9:0] o_x;
   logic [8:0] o_y;
   logic       o_active;
   logic       o_locked;
   logic       o_frame_start;
   logic [9:0] o_line_len;
   logic [9:0] o_frame_lines;

   modport master (
      output i_pix_stb, i_hs, i_vs,
      input  o_x, o_y, o_active, o_locked, o_frame_start, o_line_len, o_frame_lines
   );

   modport slave (
      input  i_pix_stb, i_hs, i_vs,
      output o_x, o_y, o_active, o_locked, o_frame_start, o_line_len, o_frame_lines
   );
endinterface
`default_nettype wire

// File: rtl/vga_sync_decoder.sv
`default_nettype none
//==============================================================================
// Module  : vga_sync_decoder
// Brief   : Recovers x/y position, active window and lock from HS/VS sync.
// Revision: 1.0
//==============================================================================
module vga_sync_decoder #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  wire logic         i_clk,
   input  wire logic         i_rst_n,
   vga_sync_decoder_if.slave bus
);

   localparam logic [9:0] c_h_total = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam logic [9:0] c_v_total = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);
   localparam logic [9:0] c_h_lo    = 10'(H_SYNC + H_BP);
   localparam logic [9:0] c_h_hi    = 10'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [9:0] c_v_lo    = 10'(V_SYNC + V_BP);
   localparam logic [9:0] c_v_hi    = 10'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [9:0] c_sat     = 10'h3FF;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       bad_q, bad_d;
   logic       armed_q, armed_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;
   logic [9:0] hc_q, hc_d;
   logic [9:0] vc_q, vc_d;
   logic [9:0] line_len_q, line_len_d;
   logic [9:0] frame_lines_q, frame_lines_d;
   logic       frame_start_q, frame_start_d;

   logic       w_hs_start;
   logic       w_vs_start;
   logic [9:0] w_hc_inc;
   logic [9:0] w_vc_inc;
   logic       w_line_bad;
   logic       w_frame_bad;
   logic       w_in_h;
   logic       w_in_v;
   logic       w_active;

   // armed_q blocks a false edge against the reset value of hs_q/vs_q
   assign w_hs_start  = bus.i_pix_stb && armed_q && (bus.i_hs == SYNC_POL) && (hs_q != SYNC_POL);
   assign w_vs_start  = bus.i_pix_stb && armed_q && (bus.i_vs == SYNC_POL) && (vs_q != SYNC_POL);
   assign w_hc_inc    = hc_q + 10'd1;
   assign w_vc_inc    = vc_q + 10'd1;
   assign w_line_bad  = w_hs_start && (w_hc_inc != c_h_total);
   assign w_frame_bad = (w_vc_inc != c_v_total);

   always_comb begin
      hs_d          = hs_q;
      vs_d          = vs_q;
      armed_d       = armed_q;
      hc_d          = hc_q;
      vc_d          = vc_q;
      line_len_d    = line_len_q;
      frame_lines_d = frame_lines_q;
      frame_start_d = 1'b0;
      if (bus.i_pix_stb) begin
         hs_d    = bus.i_hs;
         vs_d    = bus.i_vs;
         armed_d = 1'b1;
         if (w_hs_start) begin
            hc_d       = '0;
            line_len_d = w_hc_inc;
         end else if (hc_q != c_sat) begin
            hc_d = w_hc_inc;
         end
         // VS start owns vc even when HS starts on the same strobe
         if (w_vs_start) begin
            vc_d          = '0;
            frame_lines_d = w_vc_inc;
         end else if (w_hs_start && (vc_q != c_sat)) begin
            vc_d = w_vc_inc;
         end
         frame_start_d = w_vs_start && (state_q == LOCKED);
      end
   end

   always_comb begin
      state_d = state_q;
      bad_d   = bad_q;
      unique case (state_q)
         SEARCH: begin
            if (w_vs_start) begin
               state_d = MEASURE;
               bad_d   = 1'b0;
            end
         end
         MEASURE: begin
            if (w_line_bad) begin
               bad_d = 1'b1;
            end
            // a short line ending on the VS strobe still belongs to the measured frame
            if (w_vs_start) begin
               bad_d = 1'b0;
               if (!bad_q && !w_line_bad && !w_frame_bad) begin
                  state_d = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (w_line_bad || (w_vs_start && w_frame_bad) ||
                (hc_d == c_sat) || (vc_d == c_sat)) begin
               state_d = SEARCH;
            end
         end
         default: begin
            state_d = SEARCH;
            bad_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= SEARCH;
         bad_q         <= 1'b0;
         armed_q       <= 1'b0;
         hs_q          <= ~SYNC_POL;
         vs_q          <= ~SYNC_POL;
         hc_q          <= '0;
         vc_q          <= '0;
         line_len_q    <= '0;
         frame_lines_q <= '0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         bad_q         <= bad_d;
         armed_q       <= armed_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         line_len_q    <= line_len_d;
         frame_lines_q <= frame_lines_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign w_in_h   = (hc_q >= c_h_lo) && (hc_q < c_h_hi);
   assign w_in_v   = (vc_q >= c_v_lo) && (vc_q < c_v_hi);
   assign w_active = (state_q == LOCKED) && w_in_h && w_in_v;

   assign bus.o_active      = w_active;
   assign bus.o_locked      = (state_q == LOCKED);
   assign bus.o_x           = w_active ? (hc_q - c_h_lo) : '0;
   assign bus.o_y           = w_active ? 9'(vc_q - c_v_lo) : '0;
   assign bus.o_frame_start = frame_start_q;
   assign bus.o_line_len    = line_len_q;
   assign bus.o_frame_lines = frame_lines_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
//==============================================================================
// Module  : tb_vga_sync_decoder
// Brief   : Randomised sync stream against a frame-level model of the decoder.
// Revision: 1.0
//==============================================================================
module tb_vga_sync_decoder;

   // Reduced geometry keeps full frames short enough to lock repeatedly
   localparam int H_ACTIVE = 16, H_FP = 3, H_SYNC = 5, H_BP = 4;
   localparam int V_ACTIVE = 12, V_FP = 2, V_SYNC = 2, V_BP = 3;
   localparam bit SYNC_POL = 1'b0;
   localparam int HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_OFF = H_SYNC + H_BP;
   localparam int V_OFF = V_SYNC + V_BP;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vga_sync_decoder_if bus ();

   vga_sync_decoder #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .SYNC_POL(SYNC_POL)
   ) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: elapsed strobes/lines since the last sync starts plus lock bookkeeping
   bit        m_armed   = 0;
   bit        m_hs_prev = 0;
   bit        m_vs_prev = 0;
   int        m_since   = 0;
   int        m_lines   = 0;
   bit        m_locked  = 0;
   bit        m_seen_vs = 0;
   bit        m_frame_ok = 1;
   int        m_line_len = 0;
   int        m_frame_lines = 0;
   bit        m_fs = 0;

   function automatic int sat(input int v);
      return (v > 1023) ? 1023 : v;
   endfunction

   task automatic model_reset();
      m_armed = 0; m_hs_prev = 0; m_vs_prev = 0;
      m_since = 0; m_lines = 0;
      m_locked = 0; m_seen_vs = 0; m_frame_ok = 1;
      m_line_len = 0; m_frame_lines = 0; m_fs = 0;
   endtask

   task automatic model_step();
      bit hs_a, vs_a, hs_st, vs_st, line_good, frame_good;
      int nxt_since, nxt_lines;
      m_fs = 0;
      if (bus.i_pix_stb === 1'b1) begin
         hs_a       = (bus.i_hs === SYNC_POL);
         vs_a       = (bus.i_vs === SYNC_POL);
         hs_st      = m_armed && hs_a && !m_hs_prev;
         vs_st      = m_armed && vs_a && !m_vs_prev;
         line_good  = (m_since + 1 == HT);
         frame_good = (m_lines + 1 == VT);
         nxt_since  = hs_st ? 0 : m_since + 1;
         nxt_lines  = vs_st ? 0 : (hs_st ? m_lines + 1 : m_lines);
         if (hs_st) m_line_len = (sat(m_since) + 1) % 1024;
         if (vs_st) m_frame_lines = (sat(m_lines) + 1) % 1024;
         m_fs = vs_st && m_locked;
         if (m_locked) begin
            if ((hs_st && !line_good) || (vs_st && !frame_good) ||
                nxt_since >= 1023 || nxt_lines >= 1023) begin
               m_locked  = 0;
               m_seen_vs = 0;
            end
         end else begin
            if (hs_st && !line_good) m_frame_ok = 0;
            if (vs_st) begin
               if (m_seen_vs && m_frame_ok && frame_good) m_locked = 1;
               m_seen_vs  = 1;
               m_frame_ok = 1;
            end
         end
         m_since   = nxt_since;
         m_lines   = nxt_lines;
         m_hs_prev = hs_a;
         m_vs_prev = vs_a;
         m_armed   = 1;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // Every-cycle comparison against the model
   initial begin
      int hc, vc, e_x, e_y;
      bit e_act;
      forever begin
         @(negedge clk);
         hc    = sat(m_since);
         vc    = sat(m_lines);
         e_act = m_locked && hc >= H_OFF && hc < H_OFF + H_ACTIVE &&
                 vc >= V_OFF && vc < V_OFF + V_ACTIVE;
         e_x   = e_act ? hc - H_OFF : 0;
         e_y   = e_act ? vc - V_OFF : 0;
         n_checks++;
         if (bus.o_active !== e_act || bus.o_locked !== m_locked || bus.o_frame_start !== m_fs ||
             bus.o_x !== 10'(e_x) || bus.o_y !== 9'(e_y) ||
             bus.o_line_len !== 10'(m_line_len) || bus.o_frame_lines !== 10'(m_frame_lines)) begin
            n_errors++;
            $display("FAIL cycle_compare t=%0t act/lock/fs/x/y/len/lines got %0d/%0d/%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d/%0d/%0d",
                     $time, bus.o_active, bus.o_locked, bus.o_frame_start, bus.o_x, bus.o_y,
                     bus.o_line_len, bus.o_frame_lines, e_act, m_locked, m_fs, e_x, e_y,
                     m_line_len, m_frame_lines);
         end
      end
   end

   // Sync stream generator in decoder coordinates: HS and VS assert at pixel 0
   int gen_l = 0, gen_p = 0, last_l = -1, last_p = -1;
   int bad_line = -1, bad_len = HT, vs_shift = 0;
   bit hs_en = 1, vs_en = 1;

   task automatic step();
      int   gap, pos, rel;
      logic hs_lvl, vs_lvl;
      gap = int'($urandom_range(0, 2));
      for (int k = 0; k < gap; k++) begin
         bus.i_pix_stb = 1'b0;
         bus.i_hs      = 1'($urandom);
         bus.i_vs      = 1'($urandom);
         @(posedge clk); #1;
      end
      pos    = gen_l * HT + gen_p;
      rel    = (pos - vs_shift + HT * VT) % (HT * VT);
      hs_lvl = (hs_en && gen_p < H_SYNC) ? SYNC_POL : ~SYNC_POL;
      vs_lvl = (vs_en && rel < V_SYNC * HT) ? SYNC_POL : ~SYNC_POL;
      bus.i_pix_stb = 1'b1;
      bus.i_hs      = hs_lvl;
      bus.i_vs      = vs_lvl;
      @(posedge clk); #1;
      bus.i_pix_stb = 1'b0;
      last_l = gen_l;
      last_p = gen_p;
      gen_p++;
      if (gen_p >= ((gen_l == bad_line) ? bad_len : HT)) begin
         gen_p = 0;
         gen_l = (gen_l + 1) % VT;
      end
   endtask

   task automatic run_to(input int l, input int p);
      int n = 0;
      do begin
         step();
         n++;
      end while (!(last_l == l && last_p == p) && n < 20000);
      if (!(last_l == l && last_p == p)) begin
         n_checks++;
         n_errors++;
         $display("FAIL run_to: position %0d,%0d not reached, at %0d,%0d", l, p, last_l, last_p);
      end
   endtask

   task automatic run_frame();
      int n = 0;
      step();
      while (!(gen_l == 0 && gen_p == 0) && n < 2000) begin
         step();
         n++;
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_pix_stb = 1'b0;
      bus.i_hs      = ~SYNC_POL;
      bus.i_vs      = ~SYNC_POL;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", longint'({bus.o_active, bus.o_locked, bus.o_frame_start, bus.o_x,
                                     bus.o_y, bus.o_line_len, bus.o_frame_lines}), 0);
      rst_n = 1'b1;

      // Acquisition: first VS start measures, second locks, third pulses frame_start
      gen_l = VT - 1;
      gen_p = HT - 3;
      run_to(0, 0);
      chk("locked_after_vs1", bus.o_locked, 0);
      run_to(0, 0);
      chk("locked_after_vs2", bus.o_locked, 1);
      chk("line_len", bus.o_line_len, HT);
      chk("frame_lines", bus.o_frame_lines, VT);
      chk("fs_on_lock_edge", bus.o_frame_start, 0);
      run_to(0, 0);
      chk("fs_when_locked", bus.o_frame_start, 1);

      run_to(V_OFF, H_OFF);
      chk("first_pixel_active", bus.o_active, 1);
      chk("first_pixel_x", bus.o_x, 0);
      chk("first_pixel_y", bus.o_y, 0);
      run_to(V_OFF + V_ACTIVE - 1, H_OFF + H_ACTIVE - 1);
      chk("last_pixel_x", bus.o_x, H_ACTIVE - 1);
      chk("last_pixel_y", bus.o_y, V_ACTIVE - 1);
      run_to(V_OFF + V_ACTIVE - 1, H_OFF + H_ACTIVE);
      chk("past_window_active", bus.o_active, 0);
      chk("past_window_x", bus.o_x, 0);

      // One line a pixel short drops lock at the following HS start
      run_to(7, HT - 1);
      bad_line = 8;
      bad_len  = HT - 1;
      run_to(9, 0);
      chk("short_line_unlock", bus.o_locked, 0);
      chk("short_line_len", bus.o_line_len, HT - 1);
      bad_line = -1;
      run_to(0, 0);
      chk("relock_vs1", bus.o_locked, 0);
      run_to(0, 0);
      chk("relock_vs2", bus.o_locked, 1);

      // Missing syncs: hc saturates at 1023 and lock drops on that strobe
      run_to(6, 0);
      hs_en = 0;
      vs_en = 0;
      repeat (1022) step();
      chk("hc_1022_still_locked", bus.o_locked, 1);
      step();
      chk("hc_sat_unlock", bus.o_locked, 0);
      chk("hc_sat_active", bus.o_active, 0);
      chk("hc_sat_line_len", bus.o_line_len, HT);
      hs_en = 1;
      vs_en = 1;
      run_to(0, 0);
      run_to(0, 0);
      chk("relock_after_sat", bus.o_locked, 1);

      // Asynchronous reset in the middle of a visible line
      run_to(7, 12);
      chk("pre_reset_x", bus.o_x, 12 - H_OFF);
      chk("pre_reset_y", bus.o_y, 7 - V_OFF);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", longint'({bus.o_active, bus.o_locked, bus.o_frame_start, bus.o_x,
                                           bus.o_y, bus.o_line_len, bus.o_frame_lines}), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_to(0, 0);
      chk("post_reset_vs1", bus.o_locked, 0);
      run_to(0, 0);
      chk("post_reset_vs2", bus.o_locked, 1);

      // Random frames: shifted VS phase and odd-length lines
      for (int f = 0; f < 12; f++) begin
         int d;
         vs_shift = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, HT * VT - 1)) : 0;
         if ($urandom_range(0, 2) == 0) begin
            d        = int'($urandom_range(1, 3));
            bad_line = int'($urandom_range(0, VT - 1));
            bad_len  = ($urandom_range(0, 1) == 1) ? HT + d : HT - d;
         end else begin
            bad_line = -1;
         end
         run_frame();
      end

      vs_shift = 0;
      bad_line = -1;
      step();
      run_frame();
      step();
      run_frame();
      step();
      chk("final_locked", bus.o_locked, 1);
      chk("final_frame_lines", bus.o_frame_lines, VT);
      chk("final_line_len", bus.o_line_len, HT);

      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
